// File: rtl/ram_port_arbiter.sv
// Two-port req/gnt/ack arbiter that shares one single-port data RAM between the CPU data
// side (port 0) and the loader/debug side (port 1). Define RAM_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module ram_port_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int RD_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req,
   input  logic [1:0]            req_we,
   input  logic [2*ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0]   req_wdata,
   output logic [1:0]            gnt,
   output logic [1:0]            ack,
   output logic [2*DATA_W-1:0]   rdata,
   output logic                  ram_we,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [DATA_W-1:0]     ram_din,
   input  logic [DATA_W-1:0]     ram_dout
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   // WAIT lasts RD_LAT cycles: the counter starts at RD_LAT-1 and the capture happens at zero.
   localparam logic [2:0] WCNT_INIT = 3'(RD_LAT - 1);

   state_t              state_q, state_d;
   logic [2:0]          wcnt_q, wcnt_d;
   logic                last_gnt_q, last_gnt_d;
   logic                owner_q, owner_d;
   logic [1:0]          gnt_q, gnt_d;
   logic [1:0]          ack_q, ack_d;
   logic [2*DATA_W-1:0] rdata_q, rdata_d;
   logic                ram_we_q, ram_we_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   ram_din_q, ram_din_d;
   logic                win_s;

   function automatic logic pick_winner(input logic [1:0] r, input logic last);
      logic w;
      case (r)
         2'b01:   w = 1'b0;
         2'b10:   w = 1'b1;
`ifdef RAM_ARB_FIXED_PRIO_EN
         2'b11:   w = 1'b0 & ~(last & 1'b0);
`else
         2'b11:   w = ~last;
`endif
         default: w = 1'b0;
      endcase
      return w;
   endfunction

   // Next-state and registered-output computation.
   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      last_gnt_d = last_gnt_q;
      owner_d    = owner_q;
      gnt_d      = 2'b00;
      ack_d      = 2'b00;
      rdata_d    = rdata_q;
      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;
      win_s      = pick_winner(req, last_gnt_q);

      case (state_q)
         ST_IDLE: begin
            if (req != 2'b00) begin
               gnt_d[win_s] = 1'b1;
               last_gnt_d   = win_s;
               owner_d      = win_s;
               ram_we_d     = req_we[win_s];
               if (win_s) begin
                  ram_addr_d = req_addr[2*ADDR_W-1:ADDR_W];
                  ram_din_d  = req_wdata[2*DATA_W-1:DATA_W];
               end else begin
                  ram_addr_d = req_addr[ADDR_W-1:0];
                  ram_din_d  = req_wdata[DATA_W-1:0];
               end
               state_d = ST_ACCESS;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            // ram_we is still high here only for a write access.
            if (ram_we_q) begin
               ack_d[owner_q] = 1'b1;
               state_d        = ST_IDLE;
            end else begin
               wcnt_d  = WCNT_INIT;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (wcnt_q != 3'd0) begin
               wcnt_d = wcnt_q - 3'd1;
            end else begin
               ack_d[owner_q] = 1'b1;
               if (owner_q) begin
                  rdata_d[2*DATA_W-1:DATA_W] = ram_dout;
               end else begin
                  rdata_d[DATA_W-1:0] = ram_dout;
               end
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any in-flight access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         wcnt_q     <= 3'd0;
         last_gnt_q <= 1'b1;
         owner_q    <= 1'b0;
         gnt_q      <= 2'b00;
         ack_q      <= 2'b00;
         rdata_q    <= '0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         last_gnt_q <= last_gnt_d;
         owner_q    <= owner_d;
         gnt_q      <= gnt_d;
         ack_q      <= ack_d;
         rdata_q    <= rdata_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
      end
   end

   assign gnt      = gnt_q;
   assign ack      = ack_q;
   assign rdata    = rdata_q;
   assign ram_we   = ram_we_q;
   assign ram_addr = ram_addr_q;
   assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: RD_LAT=1 instance with a RAM model and scoreboard,
// plus an RD_LAT=3 instance fed a cycle-stamped ram_dout to pin down the capture cycle.
module tb_ram_port_arbiter;
   localparam int DW = 32;
   localparam int AW = 10;
`ifdef RAM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [1:0]       req, req_we, gnt, ack;
   logic [2*AW-1:0]  req_addr;
   logic [2*DW-1:0]  req_wdata, rdata;
   logic             ram_we;
   logic [AW-1:0]    ram_addr;
   logic [DW-1:0]    ram_din, ram_dout;

   logic [1:0]       req3, gnt3, ack3;
   logic [2*AW-1:0]  addr3;
   logic [2*DW-1:0]  rdata3;
   logic             ram_we3;
   logic [AW-1:0]    ram_addr3;
   logic [DW-1:0]    ram_din3, ram_dout3;

   ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .rdata(rdata), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .req(req3), .req_we(2'b00), .req_addr(addr3),
      .req_wdata(64'h0), .gnt(gnt3), .ack(ack3), .rdata(rdata3), .ram_we(ram_we3),
      .ram_addr(ram_addr3), .ram_din(ram_din3), .ram_dout(ram_dout3)
   );

   // Single-port RAM with one cycle of read latency.
   logic [DW-1:0] mem [0:1023];
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   typedef struct {
      int          port;
      logic        rd;
      logic [31:0] data;
   } exp_t;

   exp_t        ack_q[$];
   int          gnt_q[$];
   logic [31:0] exp_mem [logic [9:0]];
   logic [31:0] shadow [2];
   int          n_checks = 0;
   int          n_errors = 0;
   int          n_gnt    = 0;
   int          cyc      = 0;
   logic [31:0] exp3;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle, then score gnt/ack/rdata of the RD_LAT=1 instance.
   task automatic step();
      exp_t e;
      int   p;
      @(posedge clk);
      #1;
      cyc++;
      ram_dout3 = 32'hC0DE_0000 + 32'(cyc);
      chk("dual_gnt_ack", {62'h0, gnt == 2'b11, ack == 2'b11}, 64'h0);
      if (gnt != 2'b00) begin
         if (gnt_q.size() == 0) chk("gnt_unexpected", {62'h0, gnt}, 64'h0);
         else begin
            p = gnt_q.pop_front();
            n_gnt++;
            chk("gnt_port", {62'h0, gnt}, 64'(2'b01 << p));
         end
      end
      if (ack != 2'b00) begin
         if (ack_q.size() == 0) chk("ack_unexpected", {62'h0, ack}, 64'h0);
         else begin
            e = ack_q.pop_front();
            chk("ack_port", {62'h0, ack}, 64'(2'b01 << e.port));
            if (e.rd) shadow[e.port] = e.data;
         end
      end
      chk("rdata", rdata, {shadow[1], shadow[0]});
   endtask

   task automatic issue(input int p, input logic we, input logic [9:0] a, input logic [31:0] d);
      exp_t e;
      req[p]                 = 1'b1;
      req_we[p]              = we;
      req_addr[p*AW +: AW]   = a;
      req_wdata[p*DW +: DW]  = d;
      gnt_q.push_back(p);
      e.port = p;
      e.rd   = ~we;
      if (we) begin
         exp_mem[a] = d;
         e.data     = 32'h0;
      end else begin
         e.data = exp_mem[a];
      end
      ack_q.push_back(e);
   endtask

   initial begin
      exp_t e;
      rst = 1'b0; req = 2'b00; req_we = 2'b00; req_addr = '0; req_wdata = '0;
      req3 = 2'b00; addr3 = '0; ram_dout3 = 32'h0;
      shadow[0] = 32'h0; shadow[1] = 32'h0;

      // Reset state
      step();
      chk("rst_gnt_ack", {56'h0, gnt, ack, gnt3, ack3}, 64'h0);
      chk("rst_ram", {53'h0, ram_we, ram_addr}, 64'h0);
      chk("rst_din", {32'h0, ram_din}, 64'h0);
      rst = 1'b1;
      step();

      // Port 0 write 0x005 = DEADBEEF
      issue(0, 1'b1, 10'h005, 32'hDEADBEEF);
      step();
      chk("t1_gnt", {62'h0, gnt}, 64'h1);
      chk("t1_we", {63'h0, ram_we}, 64'h1);
      chk("t1_addr", {54'h0, ram_addr}, 64'h005);
      chk("t1_din", {32'h0, ram_din}, 64'hDEADBEEF);
      req = 2'b00;
      step();
      chk("t1_ack", {62'h0, ack}, 64'h1);
      chk("t1_we_off", {63'h0, ram_we}, 64'h0);

      // Port 1 write 0x00A, then port 1 read 0x005
      issue(1, 1'b1, 10'h00A, 32'h0BADF00D);
      step();
      chk("t2w_gnt", {62'h0, gnt}, 64'h2);
      req = 2'b00;
      step();
      chk("t2w_ack", {62'h0, ack}, 64'h2);
      issue(1, 1'b0, 10'h005, 32'h0);
      step();
      chk("t2_gnt", {62'h0, gnt}, 64'h2);
      chk("t2_addr_rd", {53'h0, ram_we, ram_addr}, 64'h005);
      req = 2'b00;
      step();
      chk("t2_ack_early", {62'h0, ack}, 64'h0);
      step();
      chk("t2_ack", {62'h0, ack}, 64'h2);
      chk("t2_rdata1", {32'h0, rdata[63:32]}, 64'hDEADBEEF);
      chk("t2_rdata0", {32'h0, rdata[31:0]}, 64'h0);

      // Both ports read continuously for 20 cycles
      req_we = 2'b00;
      req_addr = {10'h00A, 10'h005};
      req = 2'b11;
      for (int k = 0; k < 7; k++) begin
         e.port = FIXED ? 0 : (k % 2);
         e.rd   = 1'b1;
         e.data = exp_mem[(e.port == 1) ? 10'h00A : 10'h005];
         gnt_q.push_back(e.port);
         ack_q.push_back(e);
      end
      n_gnt = 0;
      for (int k = 0; k < 20; k++) step();
      req = 2'b00;
      repeat (4) step();
      chk("t3_gnt_count", 64'(n_gnt), 64'd7);
      chk("t3_queues_empty", 64'(gnt_q.size() + ack_q.size()), 64'd0);

      // RD_LAT=3 read on the second instance
      addr3 = {10'h000, 10'h07F};
      req3  = 2'b01;
      step();
      chk("t4_gnt", {62'h0, gnt3}, 64'h1);
      chk("t4_addr", {54'h0, ram_addr3}, 64'h07F);
      req3 = 2'b00;
      step();
      chk("t4_ack_c2", {62'h0, ack3}, 64'h0);
      step();
      chk("t4_ack_c3", {62'h0, ack3}, 64'h0);
      step();
      chk("t4_ack_c4", {62'h0, ack3}, 64'h0);
      exp3 = 32'hC0DE_0000 + 32'(cyc);
      step();
      chk("t4_ack", {62'h0, ack3}, 64'h1);
      chk("t4_rdata", rdata3, {32'h0, exp3});

      // Reset in the WAIT cycle of a read
      req[0] = 1'b1; req_we[0] = 1'b0; req_addr[9:0] = 10'h00A;
      gnt_q.push_back(0);
      step();
      chk("t5_gnt", {62'h0, gnt}, 64'h1);
      req = 2'b00;
      step();
      rst = 1'b0;
      shadow[0] = 32'h0;
      shadow[1] = 32'h0;
      #1;
      chk("t5_ctl_clear", {51'h0, gnt, ack, ram_we, ram_addr}, 64'h0);
      chk("t5_din_clear", {32'h0, ram_din}, 64'h0);
      chk("t5_rdata_clear", rdata, 64'h0);
      step();
      chk("t5_no_ack", {62'h0, ack}, 64'h0);
      rst = 1'b1;
      step();
      chk("t5_no_ack2", {62'h0, ack}, 64'h0);

      // Tie after reset goes to port 0, then port 1 is served
      req_we = 2'b00;
      issue(0, 1'b0, 10'h005, 32'h0);
      issue(1, 1'b0, 10'h00A, 32'h0);
      step();
      chk("t5_tie_first", {62'h0, gnt}, 64'h1);
      req = 2'b10;
      step();
      step();
      chk("t5_ack0", {62'h0, ack}, 64'h1);
      step();
      chk("t5_gnt1", {62'h0, gnt}, 64'h2);
      req = 2'b00;
      step();
      step();
      chk("t5_ack1", {62'h0, ack}, 64'h2);
      chk("t5_rdata", rdata, {32'h0BADF00D, 32'hDEADBEEF});
      chk("t5_queues_empty", 64'(gnt_q.size() + ack_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port data RAM between two requesters: port 0 is the CPU controller data side; port 1 is the loader/debug side.
- Uses a req/gnt/ack handshake per port, with round-robin arbitration between the ports.
- All RAM-side outputs are registered.
- Sits between the requesters and the RAM. The RAM's we/din/dout/addr connect only here.

Parameters:
- DATA_W, 32: RAM word width; equals MEMORY_WORD_SIZE.
- ADDR_W, 10: RAM address width; equals RAM_SIZE.
- RD_LAT, 1: cycles from the RAM sampling an address to dout being valid. Legal range is 1..7.

Ports:
- clk  input  1  system clock; rising edge.
- rst  input  1  asynchronous, active-low reset; the block is in reset while rst=0.
- req  input  2  per-port request level; bit i belongs to port i.
- req_we  input  2  per-port access type: 1 = write, 0 = read.
- req_addr  input  2*ADDR_W  per-port address; port i uses [i*ADDR_W +: ADDR_W].
- req_wdata  input  2*DATA_W  per-port write data; same slicing scheme.
- gnt  output  2  one-cycle pulse: the port's request is accepted.
- ack  output  2  one-cycle pulse: the access is complete; read data is valid.
- rdata  output  2*DATA_W  per-port read data, held between reads.
- ram_we  output  1  RAM write enable.
- ram_addr  output  ADDR_W  RAM address.
- ram_din  output  DATA_W  RAM write data.
- ram_dout  input  DATA_W  RAM read data.

Behaviour:
- Reset (rst=0), asynchronous and valid at any time, including mid-access:
  - State goes to IDLE.
  - gnt, ack, ram_we, ram_addr, ram_din and rdata all go to 0.
  - last_gnt goes to 1, so port 0 wins the first tie.
  - Any in-flight access is dropped; no ack is issued for it.
- States: IDLE, ACCESS, WAIT. The counter wcnt is 3 bits wide.
- IDLE:
  - req is sampled only in this state.
  - If any req bit is set, pick winner w:
    - If only one bit is set, that port wins.
    - If both bits are set, the port other than last_gnt wins.
  - At the clock edge:
    - gnt[w] <= 1, last_gnt <= w, owner <= w.
    - ram_addr, ram_we and ram_din load from port w's inputs.
    - State goes to ACCESS.
  - If req is 0, stay in IDLE with ram_we=0.
- ACCESS (one cycle; the RAM samples at the end of it):
  - gnt returns to 0.
  - ram_we <= 0 at the exit edge, so a write is exactly one cycle long.
  - For a write: ack[owner] <= 1 and state goes to IDLE.
  - For a read: wcnt <= RD_LAT-1 and state goes to WAIT.
- WAIT:
  - If wcnt != 0, decrement wcnt.
  - If wcnt == 0: rdata[owner] <= ram_dout, ack[owner] <= 1, state goes to IDLE.
- Latency, measured from the IDLE cycle in which req is seen (cycle 0):
  - gnt is high in cycle 1.
  - A write's ack is high in cycle 2.
  - A read's ack and rdata are valid in cycle 2+RD_LAT.
  - The ack cycle is also an IDLE cycle, so a new arbitration happens in that same cycle.
- Requester rules:
  - Hold req, req_we, req_addr and req_wdata stable until gnt is seen.
  - Drop req in the cycle after gnt unless a new access is intended.
  - Inputs are don't-care outside IDLE.
- ack and gnt are never high on both ports in the same cycle.
- At most one access is outstanding at a time.
- A write never changes rdata. rdata for a port changes only on that port's read ack.
- Under continuous requests from both ports, grants strictly alternate 0,1,0,1.

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN.
- When defined: port 0 always wins a tie, and last_gnt is ignored. Port 1 can starve; this is intended for debug halt only.
- When undefined: the round-robin rule above applies.

Test Plan:
- Reset, then port 0 writes addr 0x005, data 0xDEADBEEF -> gnt[0] in cycle 1; ram_we=1 with ram_addr=0x005 in cycle 1; ack[0] in cycle 2.
- Port 1 reads 0x005 with RD_LAT=1 and ram_dout=0xDEADBEEF -> gnt[1] in cycle 1; ack[1] and rdata[1]=0xDEADBEEF in cycle 3; rdata[0] unchanged.
- Both ports hold req for reads for 20 cycles -> grants alternate 0,1,0,1 starting with port 0; no dual gnt or dual ack in any cycle.
- RD_LAT=3 read -> ack in cycle 5; ram_dout is captured at the end of the third WAIT cycle.
- rst driven to 0 in the WAIT cycle of a read -> outputs clear immediately; no ack follows; the next request is served normally from IDLE.
- RAM_ARB_FIXED_PRIO_EN defined, both ports requesting continuously -> every gnt goes to port 0.
